gb_apu_noise_ctrl: RTL

Control front end for the APU noise channel (channel 4). It decodes CPU writes to NR41–NR44 into the channel's register fields and issues the one-cycle `start` trigger pulse. It also generates the 512 Hz frame-sequencer strobes `clk_length_ctr` and `clk_vol_env` that the noise channel consumes. It sits between the APU bus decoder and `gb_apu_channel_noise`, and drives every control input of that channel.

---
 rtl/gb_apu_noise_ctrl_if.sv | 10 +
 rtl/gb_apu_noise_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/gb_apu_noise_ctrl_if.sv
// rtl/gb_apu_noise_ctrl_if.sv - APU bus register port for the noise-channel control block
interface gb_apu_noise_ctrl_if;
  logic       wr_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output wr_en, addr, wdata, input rdata);
  modport slave  (input wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/gb_apu_noise_ctrl.sv
// rtl/gb_apu_noise_ctrl.sv - NR41-NR44 decode, trigger pulse and 512 Hz frame-sequencer strobes
module gb_apu_noise_ctrl #(
  parameter int FS_DIV = 8192
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 apu_enable,
  gb_apu_noise_ctrl_if.slave   bus,
  output logic [5:0]           length,
  output logic [3:0]           initial_volume,
  output logic                 envelope_increasing,
  output logic [2:0]           num_envelope_sweeps,
  output logic [3:0]           shift_clock_freq,
  output logic                 counter_width,
  output logic [2:0]           freq_dividing_ratio,
  output logic                 single,
  output logic                 start,
  output logic                 clk_length_ctr,
  output logic                 clk_vol_env
);
  localparam int PW = $clog2(FS_DIV);

  logic [PW-1:0] presc;
  logic [2:0]    step;
  logic [2:0]    step_nxt;
  logic          presc_wrap;
  logic [7:0]    rdata_c;

  assign step_nxt   = step + 3'd1;
  assign presc_wrap = (presc == PW'(FS_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !apu_enable) begin
      // Step parks at 7 so the first wrap after enable lands on step 0.
      length              <= '0;
      initial_volume      <= '0;
      envelope_increasing <= 1'b0;
      num_envelope_sweeps <= '0;
      shift_clock_freq    <= '0;
      counter_width       <= 1'b0;
      freq_dividing_ratio <= '0;
      single              <= 1'b0;
      start               <= 1'b0;
      clk_length_ctr      <= 1'b0;
      clk_vol_env         <= 1'b0;
      presc               <= '0;
      step                <= 3'd7;
    end else begin
      start <= bus.wr_en && (bus.addr == 2'd3) && bus.wdata[7];
      if (bus.wr_en) begin
        case (bus.addr)
          2'd0: length <= bus.wdata[5:0];
          2'd1: begin
            initial_volume      <= bus.wdata[7:4];
            envelope_increasing <= bus.wdata[3];
            num_envelope_sweeps <= bus.wdata[2:0];
          end
          2'd2: begin
            shift_clock_freq    <= bus.wdata[7:4];
            counter_width       <= bus.wdata[3];
            freq_dividing_ratio <= bus.wdata[2:0];
          end
          default: single <= bus.wdata[6];
        endcase
      end
      if (presc_wrap) begin
        presc          <= '0;
        step           <= step_nxt;
        clk_length_ctr <= ~step_nxt[0];
        clk_vol_env    <= (step_nxt == 3'd7);
      end else begin
        presc          <= presc + PW'(1);
        clk_length_ctr <= 1'b0;
        clk_vol_env    <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_c = 8'hFF;
    case (bus.addr)
      2'd0: rdata_c = 8'hFF;
      2'd1: rdata_c = {initial_volume, envelope_increasing, num_envelope_sweeps};
      2'd2: rdata_c = {shift_clock_freq, counter_width, freq_dividing_ratio};
      default: rdata_c = {1'b1, single, 6'b111111};
    endcase
  end

  assign bus.rdata = rdata_c;
endmodule
